// File: rtl/barrel_coord_gen.sv
// Barrel-distortion request generator: walks the output raster in order and
// issues clamped source coordinates through a 5-stage, stall-able pipeline.
module barrel_coord_gen #(
  parameter int unsigned        WIDTH  = 1080,
  parameter int unsigned        HEIGHT = 960,
  parameter int unsigned        CX     = 540,
  parameter int unsigned        CY     = 480,
  parameter logic signed [15:0] K      = -16'sd1,
  parameter int unsigned        KSHIFT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        Math_Ready,
  input  logic        AXIS_Out_tReady,
  output logic [11:0] Math_X,
  output logic [11:0] Math_Y,
  output logic        Math_Vaild,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [11:0]        OX_LAST = 12'(WIDTH - 1);
  localparam logic [11:0]        OY_LAST = 12'(HEIGHT - 1);
  localparam logic signed [12:0] CX_S    = 13'(CX);
  localparam logic signed [12:0] CY_S    = 13'(CY);
  localparam logic signed [31:0] CX_W    = 32'(CX);
  localparam logic signed [31:0] CY_W    = 32'(CY);
  localparam logic signed [39:0] K_W     = 40'(K);
  localparam logic signed [40:0] F_ONE   = 41'sd16384;
  localparam logic signed [40:0] F_MAX   = 41'sd32767;

  function automatic logic [15:0] sat_q14(input logic signed [40:0] v);
    logic [15:0] r;
    if (v < 41'sd0) begin
      r = 16'd0;
    end else if (v > F_MAX) begin
      r = 16'd32767;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [11:0] clamp_coord(input logic signed [31:0] v, input logic [11:0] hi);
    logic [11:0] r;
    if (v < 32'sd0) begin
      r = 12'd0;
    end else if (v > $signed({20'd0, hi})) begin
      r = hi;
    end else begin
      r = v[11:0];
    end
    return r;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [11:0] r_ox, r_oy, w_ox_nxt, w_oy_nxt;
  logic        w_en, w_issue, w_last_done, w_all_idle;
  logic        r_busy, r_frame_done;

  logic                r_s1_v, r_s2_v, r_s3_v, r_s4_v, r_s5_v;
  logic signed [12:0]  r_s1_dx, r_s1_dy, r_s2_dx, r_s2_dy, r_s3_dx, r_s3_dy;
  logic [22:0]         r_s1_dxsq, r_s1_dysq;
  logic signed [39:0]  r_s2_p;
  logic [15:0]         r_s3_f;
  logic signed [29:0]  r_s4_mx, r_s4_my;
  logic [11:0]         r_s5_x, r_s5_y;

  logic signed [12:0]  w_dx, w_dy;
  logic signed [22:0]  w_dxe, w_dye;
  logic [22:0]         w_dxsq, w_dysq, w_r2;
  logic signed [39:0]  w_r2e, w_p, w_psh;
  logic signed [40:0]  w_fsum;
  logic signed [29:0]  w_dx30, w_dy30, w_f30, w_mx, w_my, w_mxs, w_mys;
  logic signed [31:0]  w_sx, w_sy;

  assign w_en       = !r_s5_v || AXIS_Out_tReady;
  assign w_all_idle = !(r_s1_v || r_s2_v || r_s3_v || r_s4_v || r_s5_v);

  // S1 operands: offsets from the distortion centre and their squares
  assign w_dx   = $signed({1'b0, r_ox}) - CX_S;
  assign w_dy   = $signed({1'b0, r_oy}) - CY_S;
  assign w_dxe  = {{10{w_dx[12]}}, w_dx};
  assign w_dye  = {{10{w_dy[12]}}, w_dy};
  assign w_dxsq = w_dxe * w_dxe;
  assign w_dysq = w_dye * w_dye;

  assign w_r2   = r_s1_dxsq + r_s1_dysq;
  assign w_r2e  = $signed({17'd0, w_r2});
  assign w_p    = K_W * w_r2e;

  assign w_psh  = r_s2_p >>> KSHIFT;
  assign w_fsum = $signed({w_psh[39], w_psh}) + F_ONE;

  assign w_dx30 = {{17{r_s3_dx[12]}}, r_s3_dx};
  assign w_dy30 = {{17{r_s3_dy[12]}}, r_s3_dy};
  assign w_f30  = $signed({14'd0, r_s3_f});
  assign w_mx   = w_dx30 * w_f30;
  assign w_my   = w_dy30 * w_f30;

  // Q1.14 scaling back to pixels uses a floor shift, then recentres
  assign w_mxs  = r_s4_mx >>> 5'd14;
  assign w_mys  = r_s4_my >>> 5'd14;
  assign w_sx   = $signed({{2{w_mxs[29]}}, w_mxs}) + CX_W;
  assign w_sy   = $signed({{2{w_mys[29]}}, w_mys}) + CY_W;

  // Next-state, raster advance and issue decision
  always_comb begin
    w_state_nxt = r_state;
    w_ox_nxt    = r_ox;
    w_oy_nxt    = r_oy;
    w_issue     = 1'b0;
    w_last_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_FILL;
        else       w_state_nxt = ST_IDLE;
      end
      ST_FILL: begin
        if (Math_Ready) w_state_nxt = ST_RUN;
        else            w_state_nxt = ST_FILL;
      end
      ST_RUN: begin
        if (w_en && Math_Ready) begin
          w_issue = 1'b1;
          if (r_ox == OX_LAST) begin
            w_ox_nxt = 12'd0;
            if (r_oy == OY_LAST) begin
              w_oy_nxt    = 12'd0;
              w_state_nxt = ST_DRAIN;
            end else begin
              w_oy_nxt = r_oy + 12'd1;
            end
          end else begin
            w_ox_nxt = r_ox + 12'd1;
          end
        end else begin
          w_issue = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (w_all_idle) begin
          w_state_nxt = ST_IDLE;
          w_last_done = 1'b1;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, raster counters and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_ox         <= 12'd0;
      r_oy         <= 12'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ox         <= w_ox_nxt;
      r_oy         <= w_oy_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_done <= w_last_done;
    end
  end

  // Five pipeline stages; the whole pipe freezes while the output is stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v <= 1'b0;  r_s1_dx <= 13'sd0; r_s1_dy <= 13'sd0;
      r_s1_dxsq <= 23'd0; r_s1_dysq <= 23'd0;
      r_s2_v <= 1'b0;  r_s2_dx <= 13'sd0; r_s2_dy <= 13'sd0; r_s2_p <= 40'sd0;
      r_s3_v <= 1'b0;  r_s3_dx <= 13'sd0; r_s3_dy <= 13'sd0; r_s3_f <= 16'd0;
      r_s4_v <= 1'b0;  r_s4_mx <= 30'sd0; r_s4_my <= 30'sd0;
      r_s5_v <= 1'b0;  r_s5_x  <= 12'd0;  r_s5_y  <= 12'd0;
    end else if (w_en) begin
      r_s1_v    <= w_issue;
      r_s1_dx   <= w_dx;
      r_s1_dy   <= w_dy;
      r_s1_dxsq <= w_dxsq;
      r_s1_dysq <= w_dysq;
      r_s2_v    <= r_s1_v;
      r_s2_dx   <= r_s1_dx;
      r_s2_dy   <= r_s1_dy;
      r_s2_p    <= w_p;
      r_s3_v    <= r_s2_v;
      r_s3_dx   <= r_s2_dx;
      r_s3_dy   <= r_s2_dy;
      r_s3_f    <= sat_q14(w_fsum);
      r_s4_v    <= r_s3_v;
      r_s4_mx   <= w_mx;
      r_s4_my   <= w_my;
      r_s5_v    <= r_s4_v;
      r_s5_x    <= clamp_coord(w_sx, OX_LAST);
      r_s5_y    <= clamp_coord(w_sy, OY_LAST);
    end else begin
      r_s5_v <= r_s5_v;
    end
  end

  assign Math_X     = r_s5_x;
  assign Math_Y     = r_s5_y;
  assign Math_Vaild = r_s5_v;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_barrel_coord_gen.sv
// Scoreboard bench: three 8x4 instances (identity, strong +K, strong -K) run in
// lockstep, plus two full-size instances checked on their first 64 requests.
module tb_barrel_coord_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, m_ready, t_ready, rst_big, start_big;
  logic [11:0] xa, ya, xb, yb, xc, yc, xd, yd, xp, yp;
  logic        va, vb, vc, vd, vp;
  logic        busya, busyb, busyc, busyd, busyp;
  logic        fda, fdb, fdc, fdd, fdp;

  int n_tests = 0, n_fail = 0;
  int fd_a = 0, fd_b = 0, fd_c = 0, exp_frames = 0, big_cnt = 0;

  typedef struct { int xa; int ya; int xb; int yb; int xc; int yc; } sexp_t;
  typedef struct { int xd; int yd; int xp; int yp; } bexp_t;
  sexp_t sq[$];
  bexp_t bq[$];

  barrel_coord_gen #(.WIDTH(8), .HEIGHT(4), .CX(3), .CY(1), .K(16'sd0), .KSHIFT(10)) u_a (
    .clk(clk), .reset(reset), .start(start), .Math_Ready(m_ready), .AXIS_Out_tReady(t_ready),
    .Math_X(xa), .Math_Y(ya), .Math_Vaild(va), .busy(busya), .frame_done(fda));
  barrel_coord_gen #(.WIDTH(8), .HEIGHT(4), .CX(4), .CY(2), .K(16'sd8000), .KSHIFT(2)) u_b (
    .clk(clk), .reset(reset), .start(start), .Math_Ready(m_ready), .AXIS_Out_tReady(t_ready),
    .Math_X(xb), .Math_Y(yb), .Math_Vaild(vb), .busy(busyb), .frame_done(fdb));
  barrel_coord_gen #(.WIDTH(8), .HEIGHT(4), .CX(4), .CY(2), .K(-16'sd8000), .KSHIFT(2)) u_c (
    .clk(clk), .reset(reset), .start(start), .Math_Ready(m_ready), .AXIS_Out_tReady(t_ready),
    .Math_X(xc), .Math_Y(yc), .Math_Vaild(vc), .busy(busyc), .frame_done(fdc));
  barrel_coord_gen u_d (
    .clk(clk), .reset(rst_big), .start(start_big), .Math_Ready(m_ready), .AXIS_Out_tReady(t_ready),
    .Math_X(xd), .Math_Y(yd), .Math_Vaild(vd), .busy(busyd), .frame_done(fdd));
  barrel_coord_gen #(.K(16'sd8)) u_p (
    .clk(clk), .reset(rst_big), .start(start_big), .Math_Ready(m_ready), .AXIS_Out_tReady(t_ready),
    .Math_X(xp), .Math_Y(yp), .Math_Vaild(vp), .busy(busyp), .frame_done(fdp));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  // Reference mapping straight from the radial formula, using floor division
  function automatic void ref_xy(input int w, h, cx, cy, k, ks, ox, oy, output int sx, output int sy);
    longint dx, dy, r2, f, tx, ty;
    dx = ox - cx;
    dy = oy - cy;
    r2 = dx * dx + dy * dy;
    f  = 16384 + fdiv(longint'(k) * r2, longint'(1) << ks);
    if (f < 0) f = 0;
    if (f > 32767) f = 32767;
    tx = cx + fdiv(dx * f, 16384);
    ty = cy + fdiv(dy * f, 16384);
    if (tx < 0) tx = 0; else if (tx > w - 1) tx = w - 1;
    if (ty < 0) ty = 0; else if (ty > h - 1) ty = h - 1;
    sx = int'(tx);
    sy = int'(ty);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    sexp_t e;
    for (int oy = 0; oy < 4; oy++) begin
      for (int ox = 0; ox < 8; ox++) begin
        ref_xy(8, 4, 3, 1, 0, 10, ox, oy, e.xa, e.ya);
        ref_xy(8, 4, 4, 2, 8000, 2, ox, oy, e.xb, e.yb);
        ref_xy(8, 4, 4, 2, -8000, 2, ox, oy, e.xc, e.yc);
        sq.push_back(e);
      end
    end
  endtask

  task automatic push_big();
    bexp_t e;
    for (int ox = 0; ox < 64; ox++) begin
      if (ox == 0) begin
        e = '{xd: 16, yd: 14, xp: 0, yp: 0};
      end else begin
        ref_xy(1080, 960, 540, 480, -1, 10, ox, 0, e.xd, e.yd);
        ref_xy(1080, 960, 540, 480, 8, 10, ox, 0, e.xp, e.yp);
      end
      bq.push_back(e);
    end
  endtask

  // Runs until a frame_done is seen; counts valid cycles and bubbles between them
  task automatic collect(input int drop_at, input bit rnd, output int ones, output int gaps, output bit done);
    int first, last, fd0;
    first = -1; last = -1; ones = 0; done = 1'b0; fd0 = fd_a;
    for (int k = 0; k < 2000; k++) begin
      if (rnd) begin
        m_ready = ($urandom_range(0, 4) != 0);
        t_ready = ($urandom_range(0, 3) != 0);
      end else begin
        m_ready = !(k >= drop_at && k < drop_at + 3);
        t_ready = 1'b1;
      end
      if (va) begin
        ones++;
        if (first < 0) first = k;
        last = k;
      end
      tick();
      if (fd_a != fd0) begin
        done = 1'b1;
        break;
      end
    end
    gaps = (first < 0) ? 0 : (last - first + 1 - ones);
    m_ready = 1'b1;
    t_ready = 1'b1;
  endtask

  // Scoreboard monitor for the 8x4 instances
  always @(negedge clk) begin
    if (reset && va && t_ready) begin
      if (sq.size() == 0) begin
        chk("extra_xfer", 64'd1, 64'd0);
      end else begin
        sexp_t e;
        e = sq.pop_front();
        chk("a_x", xa, e.xa);  chk("a_y", ya, e.ya);
        chk("b_vld", vb, 1);   chk("b_x", xb, e.xb);  chk("b_y", yb, e.yb);
        chk("c_vld", vc, 1);   chk("c_x", xc, e.xc);  chk("c_y", yc, e.yc);
      end
    end
    if (fda) begin
      fd_a++;
      chk("fd_after_last", sq.size(), 0);
    end
    if (fdb) fd_b++;
    if (fdc) fd_c++;
  end

  // Scoreboard monitor for the full-size instances
  always @(negedge clk) begin
    if (rst_big && vd && t_ready && bq.size() > 0) begin
      bexp_t e;
      e = bq.pop_front();
      chk("big_d_x", xd, e.xd); chk("big_d_y", yd, e.yd);
      chk("big_p_vld", vp, 1);  chk("big_p_x", xp, e.xp); chk("big_p_y", yp, e.yp);
      big_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  ones, gaps, fd_before;
    bit  done;
    reset = 1'b0; rst_big = 1'b0; start = 1'b0; start_big = 1'b0;
    m_ready = 1'b1; t_ready = 1'b1;
    repeat (2) tick();
    chk("rst_x", xa, 0);  chk("rst_y", ya, 0);  chk("rst_vld", va, 0);
    chk("rst_busy", busya, 0); chk("rst_fd", fda, 0);
    chk("rst_b", {vb, busyb, fdb, vc, busyc, fdc}, 0);
    chk("rst_big", {xd, yd, vd, busyd, fdd, vp, busyp, fdp}, 0);
    reset = 1'b1; rst_big = 1'b1;
    tick();

    // Full-size parameters: first 64 requests of row 0, random stalls
    push_big();
    start_big = 1'b1; tick(); start_big = 1'b0;
    chk("big_busy_d", busyd, 1); chk("big_busy_p", busyp, 1);
    for (int k = 0; k < 400 && bq.size() > 0; k++) begin
      t_ready = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 4) != 0);
      tick();
    end
    t_ready = 1'b1; m_ready = 1'b1;
    chk("big_cnt", big_cnt, 64);
    chk("big_no_fd", {fdd, fdp}, 0);
    rst_big = 1'b0;

    // Back-to-back frame: latency and consecutive transfers
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("lat_before", va, 0);
    tick();
    chk("lat_first", va, 1);
    collect(-100, 1'b0, ones, gaps, done);
    exp_frames++;
    chk("t1_done", done, 1); chk("t1_ones", ones, 32); chk("t1_gaps", gaps, 0);
    chk("t1_left", sq.size(), 0);
    tick();
    chk("t1_idle", busya, 0);

    // Output stall for 10 cycles, then an ignored mid-frame start
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    repeat (12) tick();
    chk("t2_vld", va, 1);
    t_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_vld", va, 1);
      if (sq.size() > 0) begin
        chk("stall_x", xa, sq[0].xa);
        chk("stall_y", ya, sq[0].ya);
      end
    end
    t_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    collect(-100, 1'b0, ones, gaps, done);
    exp_frames++;
    chk("t2_done", done, 1); chk("t2_left", sq.size(), 0);

    // Buffer not ready at start, then a 3-cycle drop mid-row
    m_ready = 1'b0;
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fill_busy", busya, 1);
      chk("fill_novld", va, 0);
    end
    collect(10, 1'b0, ones, gaps, done);
    exp_frames++;
    chk("t3_done", done, 1); chk("t3_ones", ones, 32); chk("t3_gaps", gaps, 3);
    chk("t3_left", sq.size(), 0);

    // Random Math_Ready / tReady frames
    for (int f = 0; f < 3; f++) begin
      push_frame();
      start = 1'b1; tick(); start = 1'b0;
      collect(-100, 1'b1, ones, gaps, done);
      exp_frames++;
      chk("rnd_done", done, 1); chk("rnd_left", sq.size(), 0);
    end

    // Asynchronous reset mid-frame, then a clean frame
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    repeat (15) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_x", xa, 0); chk("arst_y", ya, 0); chk("arst_vld", va, 0);
    chk("arst_busy", busya, 0); chk("arst_fd", fda, 0);
    chk("arst_bc", {vb, vc, busyb, busyc}, 0);
    sq.delete();
    fd_before = fd_a;
    repeat (3) tick();
    chk("arst_no_fd", fd_a, fd_before);
    reset = 1'b1;
    tick();
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    collect(-100, 1'b0, ones, gaps, done);
    exp_frames++;
    chk("t5_done", done, 1); chk("t5_ones", ones, 32); chk("t5_gaps", gaps, 0);
    chk("t5_left", sq.size(), 0);

    tick();
    chk("frames_a", fd_a, exp_frames);
    chk("frames_b", fd_b, exp_frames);
    chk("frames_c", fd_c, exp_frames);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/barrel_coord_gen.md
Name: barrel_coord_gen

Overview:
- Request initiator for the barrel-projection memory interface.
- Scans the output raster, computes the barrel-distorted source coordinate for each output pixel, and issues (Math_X, Math_Y, Math_Vaild) requests in raster order.
- Honours Math_Ready (buffer fill) and AXIS_Out_tReady (downstream stall).
- Emits exactly WIDTH*HEIGHT requests per frame.

Parameters:
- WIDTH, 1080, output/source line length in pixels.
- HEIGHT, 960, output/source frame height in lines.
- CX, 540, distortion centre X (unsigned, < WIDTH).
- CY, 480, distortion centre Y (unsigned, < HEIGHT).
- K, -1, signed 16-bit radial coefficient.
- KSHIFT, 10, right shift applied to K*r2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  one-cycle pulse; begins a frame from IDLE, ignored otherwise.
- Math_Ready  in  1  memory buffer holds enough rows; request issue permitted.
- AXIS_Out_tReady  in  1  downstream accepts; a request transfers when Math_Vaild && AXIS_Out_tReady.
- Math_X  out  12  source X.
- Math_Y  out  12  source Y.
- Math_Vaild  out  1  request valid.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last request transfers.

Behaviour:
- Reset (reset=0, async): FSM=IDLE, raster counters=0, all pipeline valids=0. Math_X=0, Math_Y=0, Math_Vaild=0, busy=0, frame_done=0. Reset mid-frame abandons the frame; no frame_done pulse.
- Pipeline enable: en = !Math_Vaild || AXIS_Out_tReady. When en=0, every stage, counter and output holds. Math_X/Math_Y stay stable while Math_Vaild=1 and AXIS_Out_tReady=0.
- FSM states and transitions:
  - IDLE: on start -> FILL.
  - FILL: when Math_Ready=1 -> RUN. No issue in FILL.
  - RUN: on each cycle with en && Math_Ready, issue (ox,oy) into stage 1 with valid=1, then advance ox. When ox wraps from WIDTH-1 to 0, oy increments. Cycles with en=1 and Math_Ready=0 insert a bubble (valid=0). After issuing (WIDTH-1, HEIGHT-1) -> DRAIN.
  - DRAIN: no issue; wait until all stage valids are 0 -> IDLE. frame_done=1 for the single cycle of that transition.
- Pipeline: 5 registered stages, advancing only when en=1. Latency is 5 enabled cycles from issue to Math_Vaild.
  - S1: dx = ox - CX, dy = oy - CY (signed 13b); dx2 = dx*dx, dy2 = dy*dy.
  - S2: r2 = dx2 + dy2 (unsigned 23b); p = K*r2 (signed 40b).
  - S3: f = 16384 + (p >>> KSHIFT), arithmetic shift (floor). Saturate f to [0, 32767] (Q1.14, 16b).
  - S4: mx = dx*f, my = dy*f (signed 30b).
  - S5: sx = CX + (mx >>> 14), sy = CY + (my >>> 14), both floor. Clamp sx to [0, WIDTH-1] and sy to [0, HEIGHT-1]. Register into Math_X, Math_Y; Math_Vaild = S5 valid.
- The dx, dy, ox, oy values are carried alongside each stage that needs them.
- K=0 yields the identity mapping: f=16384, (sx,sy) = (ox,oy).
- start during FILL/RUN/DRAIN is ignored.
- Math_Ready is sampled only for issue. Requests already in flight complete regardless of Math_Ready.
- Transfer count per frame is exactly WIDTH*HEIGHT, in raster order; no duplicates or drops under any stall pattern.

Test Plan:
- WIDTH=8, HEIGHT=4, K=0, Math_Ready=1, tReady=1, start pulse -> 32 transfers (0,0),(1,0)..(7,3) on consecutive cycles, first Math_Vaild 5 cycles after RUN entry, frame_done pulses once after the last.
- Default parameters, K=-1, KSHIFT=10, first request -> (Math_X, Math_Y) = (16, 14): r2=522000, f=15874.
- Default parameters, K=+8, KSHIFT=10, first request -> f=20462, raw sx=-135, raw sy ≈ -120 -> clamped (0, 0).
- Hold tReady=0 for 10 cycles with Math_Vaild=1 -> Math_X/Math_Y/Math_Vaild unchanged; on release, sequence resumes with no skipped or repeated coordinate.
- Math_Ready=0 on start -> FSM stays in FILL with busy=1 and no Math_Vaild. Raise it -> RUN. Drop it mid-row for 3 cycles -> 3 bubbles, in-flight requests still delivered, final count 32 (8x4 parameters).
- Assert reset=0 mid-frame, asynchronously between clock edges -> all outputs 0 immediately, no frame_done. After release, a new start produces a complete frame from (0,0).
